alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Collapsing issue queue between rename/dispatch and the ALU execute ports: the read side of the physical-register ready scoreboard. It accepts up to four renamed instructions per cycle and samples the scoreboard vector `PR_status` to get each source's initial readiness. It then snoops the four writeback broadcasts to wake waiting sources, and issues the oldest fully-ready entry through a valid/ready handshake. `flush_stage4` empties it.

## Interface
- `DEPTH`, 8: number of entries (≥4).
- `PR_W`, 7: physical register index width.
- `NUM_PR`, 65: number of physical registers; width of `PR_status`.
- `PAY_W`, 32: opaque payload width (opcode, immediate, ROB index).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush_stage4` in 1: pipeline flush; clears queue.
- `disp_valid` in 4: per-lane dispatch valid; lane 0 oldest.
- `disp_ready` out 1: queue can take a full 4-lane group.
- `disp_src0_en`, `disp_src1_en` in 4 each: source used.
- `disp_src0_PR`, `disp_src1_PR` in 4×PR_W each: source PRs, lane i at bits [i*PR_W +: PR_W].
- `disp_dest_en` in 4: lane writes a dest PR.
- `disp_dest_PR` in 4×PR_W: dest PRs.
- `disp_payload` in 4×PAY_W: payloads.
- `PR_status` in NUM_PR: scoreboard, 1 = value available.
- `wb_en` in 4: writeback broadcast valid (ALU0, ALU1, AGU, BRU).
- `wb_PR` in 4×PR_W: broadcast dest PRs.
- `iss_valid` out 1: an entry is ready to issue.
- `iss_ready` in 1: execute port accepts.
- `iss_src0_PR`, `iss_src1_PR`, `iss_dest_PR` out PR_W each; `iss_dest_en` out 1; `iss_payload` out PAY_W: issued entry fields.
- `count` out $clog2(DEPTH+1): occupied entries.

## Operation
- Entry fields: valid, src0/src1 PR, rdy0/rdy1, dest_en, dest_PR, payload. Entries 0..count-1 are valid; index 0 is the oldest.
- Dispatch is accepted when `disp_ready` is high and any `disp_valid` bit is set. `disp_ready` = (DEPTH − count ≥ 4), computed from registered count only; a same-cycle issue does not raise it.
- Valid lanes are written in lane order, skipping invalid lanes, at the tail. The tail is count, or count−1 if an issue fires in the same cycle.
- Initial rdy for each source, in priority order:
  - src_en=0 → 1.
  - Source equals `disp_dest_PR` of a lower lane with `disp_dest_en` and `disp_valid` → 0 (intra-group dependency).
  - Otherwise `PR_status[src]` OR a match against any `wb_en`/`wb_PR` in the same cycle.
- Wakeup: each valid entry's source matching any enabled `wb_PR` sets its rdy at the edge. This applies to entries that shift in the same cycle.
- Select: the lowest-index valid entry with rdy0&rdy1. `iss_valid` and the `iss_*` fields are combinational from registered state only; a same-cycle wakeup cannot issue.
- Issue fires on `iss_valid && iss_ready`. The selected entry is removed; entries above it shift down by one; count decrements.
- `flush_stage4` has highest priority: count→0 and all valid bits cleared; dispatch, wakeup and issue are ignored that cycle. `iss_valid` is forced to 0 and `disp_ready` forced to 0 while flush is high.
- Next count = count + accepted lanes − issued; it never exceeds DEPTH by construction.

## Timing
- Reset values: count=0, all entries invalid, `iss_valid`=0, `iss_*` fields 0, `disp_ready`=1.
- Dispatch at edge T with all sources ready → `iss_valid` at cycle T+1 (minimum dispatch-to-issue latency 1).
- Broadcast in cycle T for a waiting source → entry eligible in T+1.
- One issue per cycle maximum.
- Reset asserted mid-operation clears the queue immediately (asynchronous); state after reset equals flush state.

## Structure
- Shared package `iq_pkg`:
  - `PR_W`, `NUM_PR`, `PAY_W`, number of writeback ports (4), dispatch width (4).
  - `iq_entry_t` packed struct (valid, src0_PR, rdy0, src1_PR, rdy1, dest_en, dest_PR, payload).
- Sub-module `pr_wakeup_match`: one PR in → hit out, matched against the 4 `wb_en`/`wb_PR` pairs. It is instantiated per entry source and per dispatch source.

## Test plan
- Reset, dispatch lane0 {src0=5, src1=6, both `PR_status`=1} with `iss_ready`=1 → `iss_valid`=1 next cycle with src0=5, src1=6; count 1→0.
- Dispatch src0=10 with `PR_status[10]`=0; two cycles later `wb_en[1]`=1, `wb_PR`=10 → `iss_valid` rises exactly one cycle after the broadcast.
- 4-lane dispatch where lane2 src0 = lane0 dest 20 and `PR_status[20]`=1 → lane2 entry is not ready until `wb_PR`=20 arrives.
- Fill to count=5 (DEPTH 8) → `disp_ready`=0. Issue one → count=4 → `disp_ready`=1 the next cycle.
- Entries 0 (blocked), 1 (ready), 2 (ready) → entry 1 issues first. Entry 2 shifts to index 1 and issues next, in age order.
- `flush_stage4` concurrent with a dispatch, a wakeup and `iss_ready` → count=0, `iss_valid`=0, nothing issued, no entry retained.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types and widths for the ALU issue queue and its wakeup comparators.
package iq_pkg;

  localparam int PR_W   = 7;
  localparam int NUM_PR = 65;
  localparam int PAY_W  = 32;
  localparam int NUM_WB = 4;
  localparam int DISP_W = 4;

  typedef struct packed {
    logic             valid;
    logic [PR_W-1:0]  src0_PR;
    logic             rdy0;
    logic [PR_W-1:0]  src1_PR;
    logic             rdy1;
    logic             dest_en;
    logic [PR_W-1:0]  dest_PR;
    logic [PAY_W-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, scoreboard, writeback-broadcast and issue signals of the issue queue.
interface alu_issue_queue_if
  import iq_pkg::*;
();

  logic [DISP_W-1:0]        disp_valid;
  logic                     disp_ready;
  logic [DISP_W-1:0]        disp_src0_en;
  logic [DISP_W-1:0]        disp_src1_en;
  logic [DISP_W*PR_W-1:0]   disp_src0_PR;
  logic [DISP_W*PR_W-1:0]   disp_src1_PR;
  logic [DISP_W-1:0]        disp_dest_en;
  logic [DISP_W*PR_W-1:0]   disp_dest_PR;
  logic [DISP_W*PAY_W-1:0]  disp_payload;
  logic [NUM_PR-1:0]        PR_status;
  logic [NUM_WB-1:0]        wb_en;
  logic [NUM_WB*PR_W-1:0]   wb_PR;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [PR_W-1:0]          iss_src0_PR;
  logic [PR_W-1:0]          iss_src1_PR;
  logic [PR_W-1:0]          iss_dest_PR;
  logic                     iss_dest_en;
  logic [PAY_W-1:0]         iss_payload;

  modport master (
    output disp_valid, disp_src0_en, disp_src1_en, disp_src0_PR, disp_src1_PR,
           disp_dest_en, disp_dest_PR, disp_payload, PR_status, wb_en, wb_PR, iss_ready,
    input  disp_ready, iss_valid, iss_src0_PR, iss_src1_PR, iss_dest_PR, iss_dest_en,
           iss_payload
  );

  modport slave (
    input  disp_valid, disp_src0_en, disp_src1_en, disp_src0_PR, disp_src1_PR,
           disp_dest_en, disp_dest_PR, disp_payload, PR_status, wb_en, wb_PR, iss_ready,
    output disp_ready, iss_valid, iss_src0_PR, iss_src1_PR, iss_dest_PR, iss_dest_en,
           iss_payload
  );

endinterface

// File: rtl/pr_wakeup_match.sv
// Compares one physical register against every enabled writeback broadcast.
module pr_wakeup_match
  import iq_pkg::*;
(
  input  logic [PR_W-1:0]        pr,
  input  logic [NUM_WB-1:0]      wb_en,
  input  logic [NUM_WB*PR_W-1:0] wb_PR,
  output logic                   hit
);

  logic [NUM_WB-1:0] port_hit;

  generate
    for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_port
      assign port_hit[gi] = wb_en[gi] && (wb_PR[gi*PR_W +: PR_W] == pr);
    end
  endgenerate

  assign hit = |port_hit;

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered issue queue: 4-wide dispatch, broadcast wakeup,
// oldest-ready select with valid/ready issue.
module alu_issue_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_stage4,
  alu_issue_queue_if.slave           iq,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  iq_entry_t         entries_reg  [DEPTH];
  iq_entry_t         entries_next [DEPTH];
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [DEPTH-1:0]  hit0;
  logic [DEPTH-1:0]  hit1;
  logic [DISP_W-1:0] disp_hit0;
  logic [DISP_W-1:0] disp_hit1;
  iq_entry_t         lane_entry [DISP_W];
  logic              found;
  logic [IW-1:0]     sel;
  logic              disp_ready_int;
  logic              issue_fire;
  logic              accept;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_match
      pr_wakeup_match u_match0 (
        .pr(entries_reg[gi].src0_PR), .wb_en(iq.wb_en), .wb_PR(iq.wb_PR), .hit(hit0[gi])
      );
      pr_wakeup_match u_match1 (
        .pr(entries_reg[gi].src1_PR), .wb_en(iq.wb_en), .wb_PR(iq.wb_PR), .hit(hit1[gi])
      );
    end
    for (genvar gi = 0; gi < DISP_W; gi++) begin : g_disp_match
      pr_wakeup_match u_match0 (
        .pr(iq.disp_src0_PR[gi*PR_W +: PR_W]), .wb_en(iq.wb_en), .wb_PR(iq.wb_PR),
        .hit(disp_hit0[gi])
      );
      pr_wakeup_match u_match1 (
        .pr(iq.disp_src1_PR[gi*PR_W +: PR_W]), .wb_en(iq.wb_en), .wb_PR(iq.wb_PR),
        .hit(disp_hit1[gi])
      );
    end
  endgenerate

  // Oldest ready entry; scanning downward leaves the lowest index selected.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries_reg[i].valid && entries_reg[i].rdy0 && entries_reg[i].rdy1) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign disp_ready_int  = (count_reg <= CW'(DEPTH - DISP_W)) && !flush_stage4;
  assign iq.disp_ready   = disp_ready_int;
  assign iq.iss_valid    = found && !flush_stage4;
  assign iq.iss_src0_PR  = found ? entries_reg[sel].src0_PR : '0;
  assign iq.iss_src1_PR  = found ? entries_reg[sel].src1_PR : '0;
  assign iq.iss_dest_PR  = found ? entries_reg[sel].dest_PR : '0;
  assign iq.iss_dest_en  = found ? entries_reg[sel].dest_en : 1'b0;
  assign iq.iss_payload  = found ? entries_reg[sel].payload : '0;
  assign count           = count_reg;

  // A source produced by an older lane of the same group must wait for its
  // broadcast even if the scoreboard still shows the previous mapping ready.
  always_comb begin
    for (int l = 0; l < DISP_W; l++) begin
      logic dep0;
      logic dep1;
      dep0 = 1'b0;
      dep1 = 1'b0;
      for (int k = 0; k < l; k++) begin
        if (iq.disp_valid[k] && iq.disp_dest_en[k]) begin
          if (iq.disp_dest_PR[k*PR_W +: PR_W] == iq.disp_src0_PR[l*PR_W +: PR_W]) dep0 = 1'b1;
          if (iq.disp_dest_PR[k*PR_W +: PR_W] == iq.disp_src1_PR[l*PR_W +: PR_W]) dep1 = 1'b1;
        end
      end
      lane_entry[l].valid   = 1'b1;
      lane_entry[l].src0_PR = iq.disp_src0_PR[l*PR_W +: PR_W];
      lane_entry[l].src1_PR = iq.disp_src1_PR[l*PR_W +: PR_W];
      lane_entry[l].rdy0    = !iq.disp_src0_en[l] ? 1'b1 : dep0 ? 1'b0 :
                              (iq.PR_status[iq.disp_src0_PR[l*PR_W +: PR_W]] | disp_hit0[l]);
      lane_entry[l].rdy1    = !iq.disp_src1_en[l] ? 1'b1 : dep1 ? 1'b0 :
                              (iq.PR_status[iq.disp_src1_PR[l*PR_W +: PR_W]] | disp_hit1[l]);
      lane_entry[l].dest_en = iq.disp_dest_en[l];
      lane_entry[l].dest_PR = iq.disp_dest_PR[l*PR_W +: PR_W];
      lane_entry[l].payload = iq.disp_payload[l*PAY_W +: PAY_W];
    end
  end

  // Wakeup and collapse first, then append accepted lanes at the new tail.
  always_comb begin
    int tail;
    int slot;
    issue_fire = iq.iss_valid && iq.iss_ready;
    accept     = disp_ready_int && (|iq.disp_valid);
    tail       = int'(count_reg) - (issue_fire ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      iq_entry_t e;
      src = (issue_fire && (i >= int'(sel))) ? i + 1 : i;
      e   = '0;
      if (src < DEPTH) begin
        e = entries_reg[IW'(src)];
        if (e.valid) begin
          e.rdy0 = e.rdy0 | hit0[IW'(src)];
          e.rdy1 = e.rdy1 | hit1[IW'(src)];
        end
      end
      entries_next[i] = e;
    end
    slot = tail;
    for (int l = 0; l < DISP_W; l++) begin
      if (accept && iq.disp_valid[l] && (slot < DEPTH)) begin
        entries_next[IW'(slot)] = lane_entry[l];
        slot = slot + 1;
      end
    end
    count_next = CW'(slot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else if (flush_stage4) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= entries_next[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed checks of dispatch, wakeup, oldest-ready issue, backpressure, flush and reset.
module tb_alu_issue_queue;
  import iq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_stage4 = 1'b0;
  logic [3:0] count;
  int         checks = 0;
  int         failures = 0;

  alu_issue_queue_if bus ();

  alu_issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush_stage4(flush_stage4), .iq(bus), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_disp();
    bus.disp_valid   = '0;
    bus.disp_src0_en = '0;
    bus.disp_src1_en = '0;
    bus.disp_src0_PR = '0;
    bus.disp_src1_PR = '0;
    bus.disp_dest_en = '0;
    bus.disp_dest_PR = '0;
    bus.disp_payload = '0;
  endtask

  task automatic clear_wb();
    bus.wb_en = '0;
    bus.wb_PR = '0;
  endtask

  task automatic set_wb(input int p, input logic [PR_W-1:0] pr);
    bus.wb_en[p] = 1'b1;
    bus.wb_PR[p*PR_W +: PR_W] = pr;
  endtask

  task automatic set_lane(input int l, input logic s0en, input logic [PR_W-1:0] s0,
                          input logic s1en, input logic [PR_W-1:0] s1,
                          input logic den, input logic [PR_W-1:0] d,
                          input logic [PAY_W-1:0] pay);
    bus.disp_valid[l]   = 1'b1;
    bus.disp_src0_en[l] = s0en;
    bus.disp_src1_en[l] = s1en;
    bus.disp_src0_PR[l*PR_W +: PR_W]   = s0;
    bus.disp_src1_PR[l*PR_W +: PR_W]   = s1;
    bus.disp_dest_en[l] = den;
    bus.disp_dest_PR[l*PR_W +: PR_W]   = d;
    bus.disp_payload[l*PAY_W +: PAY_W] = pay;
  endtask

  initial begin
    clear_disp();
    clear_wb();
    bus.PR_status = '0;
    bus.iss_ready = 1'b0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("rst_iss_src0", 64'(bus.iss_src0_PR), 64'd0);
    check("rst_iss_payload", 64'(bus.iss_payload), 64'd0);
    check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: both sources ready from the scoreboard, issue next cycle.
    bus.PR_status[5] = 1'b1;
    bus.PR_status[6] = 1'b1;
    bus.PR_status[20] = 1'b1;
    bus.iss_ready = 1'b1;
    set_lane(0, 1, 7'd5, 1, 7'd6, 1, 7'd30, 32'hA1);
    step();
    clear_disp();
    check("basic_count1", 64'(count), 64'd1);
    check("basic_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("basic_src0", 64'(bus.iss_src0_PR), 64'd5);
    check("basic_src1", 64'(bus.iss_src1_PR), 64'd6);
    check("basic_dest", 64'(bus.iss_dest_PR), 64'd30);
    check("basic_payload", 64'(bus.iss_payload), 64'hA1);
    step();
    check("basic_count0", 64'(count), 64'd0);
    check("basic_iss_gone", 64'(bus.iss_valid), 64'd0);

    // Wakeup: source 10 not ready until a broadcast on port 1.
    set_lane(0, 1, 7'd10, 0, 7'd0, 0, 7'd0, 32'hC10);
    step();
    clear_disp();
    check("wake_count", 64'(count), 64'd1);
    check("wake_wait1", 64'(bus.iss_valid), 64'd0);
    step();
    check("wake_wait2", 64'(bus.iss_valid), 64'd0);
    set_wb(1, 7'd10);
    check("wake_same_cycle", 64'(bus.iss_valid), 64'd0);
    step();
    clear_wb();
    check("wake_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("wake_src0", 64'(bus.iss_src0_PR), 64'd10);
    step();
    check("wake_count0", 64'(count), 64'd0);

    // Intra-group dependency: lane2 reads lane0's dest 20 despite PR_status[20]=1.
    bus.iss_ready = 1'b0;
    set_lane(0, 1, 7'd5, 1, 7'd6, 1, 7'd20, 32'hB0);
    set_lane(1, 1, 7'd5, 0, 7'd0, 1, 7'd21, 32'hB1);
    set_lane(2, 1, 7'd20, 0, 7'd0, 1, 7'd22, 32'hB2);
    set_lane(3, 1, 7'd6, 0, 7'd0, 0, 7'd0, 32'hB3);
    step();
    clear_disp();
    check("grp_count4", 64'(count), 64'd4);
    check("grp_disp_ready4", 64'(bus.disp_ready), 64'd1);
    check("grp_iss_b0", 64'(bus.iss_payload), 64'hB0);
    bus.iss_ready = 1'b1;
    step();
    check("grp_count3", 64'(count), 64'd3);
    check("grp_iss_b1", 64'(bus.iss_payload), 64'hB1);
    step();
    bus.iss_ready = 1'b0;
    check("grp_count2", 64'(count), 64'd2);
    check("grp_skip_blocked", 64'(bus.iss_payload), 64'hB3);
    set_wb(0, 7'd20);
    step();
    clear_wb();
    check("grp_woken_oldest", 64'(bus.iss_payload), 64'hB2);
    bus.iss_ready = 1'b1;
    step();
    check("grp_count1", 64'(count), 64'd1);
    check("grp_iss_b3", 64'(bus.iss_payload), 64'hB3);
    step();
    check("grp_count0", 64'(count), 64'd0);

    // Backpressure: fill to 5, dispatch refused, one issue re-opens.
    bus.iss_ready = 1'b0;
    for (int l = 0; l < 4; l++) set_lane(l, 1, 7'd10, 0, 7'd0, 0, 7'd0, 32'hD0 + 32'(l));
    step();
    clear_disp();
    check("fill_count4", 64'(count), 64'd4);
    check("fill_ready4", 64'(bus.disp_ready), 64'd1);
    set_lane(0, 1, 7'd10, 0, 7'd0, 0, 7'd0, 32'hD4);
    step();
    check("fill_count5", 64'(count), 64'd5);
    check("fill_ready5", 64'(bus.disp_ready), 64'd0);
    step();
    clear_disp();
    check("fill_refused", 64'(count), 64'd5);
    set_wb(2, 7'd10);
    step();
    clear_wb();
    check("fill_iss_d0", 64'(bus.iss_payload), 64'hD0);
    check("fill_ready_before", 64'(bus.disp_ready), 64'd0);
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    check("fill_count_after", 64'(count), 64'd4);
    check("fill_ready_after", 64'(bus.disp_ready), 64'd1);
    check("fill_iss_d1", 64'(bus.iss_payload), 64'hD1);
    flush_stage4 = 1'b1;
    step();
    flush_stage4 = 1'b0;
    check("fill_flushed", 64'(count), 64'd0);

    // Age order: blocked oldest, ready entries issue in order.
    set_lane(0, 1, 7'd11, 0, 7'd0, 0, 7'd0, 32'hE0);
    set_lane(1, 1, 7'd5, 0, 7'd0, 0, 7'd0, 32'hE1);
    set_lane(2, 1, 7'd6, 0, 7'd0, 0, 7'd0, 32'hE2);
    step();
    clear_disp();
    check("age_count3", 64'(count), 64'd3);
    check("age_iss_e1", 64'(bus.iss_payload), 64'hE1);
    bus.iss_ready = 1'b1;
    step();
    check("age_iss_e2", 64'(bus.iss_payload), 64'hE2);
    step();
    bus.iss_ready = 1'b0;
    check("age_count1", 64'(count), 64'd1);
    check("age_none_ready", 64'(bus.iss_valid), 64'd0);

    // Flush concurrent with dispatch, wakeup and issue.
    set_wb(3, 7'd11);
    step();
    clear_wb();
    check("fl_pre_valid", 64'(bus.iss_valid), 64'd1);
    flush_stage4 = 1'b1;
    bus.iss_ready = 1'b1;
    set_lane(0, 1, 7'd5, 0, 7'd0, 0, 7'd0, 32'hF0);
    set_wb(0, 7'd11);
    #1;
    check("fl_iss_forced", 64'(bus.iss_valid), 64'd0);
    check("fl_disp_forced", 64'(bus.disp_ready), 64'd0);
    step();
    flush_stage4 = 1'b0;
    clear_disp();
    clear_wb();
    bus.iss_ready = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_iss_valid", 64'(bus.iss_valid), 64'd0);
    step();
    check("fl_nothing_kept", 64'(count), 64'd0);

    // Asynchronous reset mid-operation.
    set_lane(0, 1, 7'd5, 0, 7'd0, 0, 7'd0, 32'h99);
    step();
    clear_disp();
    check("ar_count1", 64'(count), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count0", 64'(count), 64'd0);
    check("ar_iss_valid", 64'(bus.iss_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_stays_empty", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
